window3x3_gen: RTL and testbench

- Streaming 3x3 neighbourhood generator for the bilateral filter datapath.
- Consumes the raster pixel stream drained from the upstream `sync_fifo`: one pixel per accepted cycle, row-major, frame size fixed by parameters.
- Emits one packed 3x3 window for every pixel position whose full neighbourhood lies inside the image. Border positions produce no output.
- Keeps two image lines internally so the downstream weight/sum stage sees a complete window in one cycle.

---
 rtl/img_pkg.sv | 18 +
 rtl/window3x3_gen_line_delay.sv | 30 +++
 rtl/window3x3_gen.sv | 124 ++++++++++++
 tb/tb_window3x3_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline constants: default pixel width and 3x3 window element indices.
package img_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Element k = 3*row + col; row 0 is oldest line, col 0 is oldest column.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;
    localparam int WIN_SIZE = 9;

endpackage

// File: rtl/window3x3_gen_line_delay.sv
// One-line pixel delay: synchronous RAM with registered read data, read-before-write.
module line_delay
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 640,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         rd_addr,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Access only on accepted pixels; a same-address read returns the old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            rd_data <= mem[rd_addr];
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line delays plus per-row column shift registers,
// emitting one packed window per interior pixel with a fixed two-cycle latency.
module window3x3_gen
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_vld,
    output logic [9*DATA_WIDTH-1:0] out_win,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]         col;
    logic [CW-1:0]         prev_col;
    logic [RW-1:0]         row;
    logic                  accept;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [DATA_WIDTH-1:0] line_a;
    logic [DATA_WIDTH-1:0] line_b;
    logic                  vld_q;
    logic                  elig_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] top_sh [2];
    logic [DATA_WIDTH-1:0] mid_sh [2];
    logic [DATA_WIDTH-1:0] bot_sh [2];

    assign accept = in_vld & ~rst;

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_delay_a (
        .clk     (clk),
        .en      (accept),
        .we      (accept),
        .rd_addr (col),
        .wr_addr (col),
        .wr_data (in_data),
        .rd_data (line_a)
    );

    // line_a is registered, so it is written into B one accepted pixel later, at its own column.
    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_delay_b (
        .clk     (clk),
        .en      (accept),
        .we      (accept),
        .rd_addr (col),
        .wr_addr (prev_col),
        .wr_data (line_a),
        .rd_data (line_b)
    );

    // Stage 1: raster position, newest pixel and eligibility of the accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            prev_col <= '0;
            pix_q    <= '0;
            vld_q    <= 1'b0;
            elig_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            vld_q  <= in_vld;
            elig_q <= in_vld && (row >= ROW_TWO) && (col >= COL_TWO);
            last_q <= in_vld && (row == ROW_LAST) && (col == COL_LAST);
            if (in_vld) begin
                pix_q    <= in_data;
                prev_col <= col;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Stage 2: shift the column history and capture the window of eligible pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_sh     <= '{default: '0};
            mid_sh     <= '{default: '0};
            bot_sh     <= '{default: '0};
            out_vld    <= 1'b0;
            out_win    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_vld    <= elig_q;
            frame_done <= last_q;
            if (vld_q) begin
                top_sh[0] <= top_sh[1];
                top_sh[1] <= line_b;
                mid_sh[0] <= mid_sh[1];
                mid_sh[1] <= line_a;
                bot_sh[0] <= bot_sh[1];
                bot_sh[1] <= pix_q;
            end
            if (elig_q) begin
                out_win[WIN_TL*DATA_WIDTH +: DATA_WIDTH] <= top_sh[0];
                out_win[WIN_TC*DATA_WIDTH +: DATA_WIDTH] <= top_sh[1];
                out_win[WIN_TR*DATA_WIDTH +: DATA_WIDTH] <= line_b;
                out_win[WIN_ML*DATA_WIDTH +: DATA_WIDTH] <= mid_sh[0];
                out_win[WIN_MC*DATA_WIDTH +: DATA_WIDTH] <= mid_sh[1];
                out_win[WIN_MR*DATA_WIDTH +: DATA_WIDTH] <= line_a;
                out_win[WIN_BL*DATA_WIDTH +: DATA_WIDTH] <= bot_sh[0];
                out_win[WIN_BC*DATA_WIDTH +: DATA_WIDTH] <= bot_sh[1];
                out_win[WIN_BR*DATA_WIDTH +: DATA_WIDTH] <= pix_q;
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: a 4x4 instance for directed frames and a 20x12 instance for random traffic,
// both checked every cycle against an image-array reference model.
module tb_window3x3_gen;

    localparam int DW  = 8;
    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int BW  = 20;
    localparam int BH  = 12;
    localparam int WWB = 9 * DW;

    localparam logic [WWB-1:0] S1_FIRST = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [WWB-1:0] S1_LAST  = 72'h33_32_31_23_22_21_13_12_11;
    localparam logic [WWB-1:0] F2_FIRST = 72'hA2_A1_A0_92_91_90_82_81_80;
    localparam logic [WWB-1:0] F2_LAST  = 72'hB3_B2_B1_A3_A2_A1_93_92_91;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_vld, b_vld;
    logic [DW-1:0]  s_data, b_data;
    logic           s_ovld, b_ovld;
    logic [WWB-1:0] s_win, b_win;
    logic           s_fd, b_fd;

    always #5 clk = ~clk;

    window3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut (
        .clk(clk), .rst(rst), .in_vld(s_vld), .in_data(s_data),
        .out_vld(s_ovld), .out_win(s_win), .frame_done(s_fd)
    );

    window3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_big (
        .clk(clk), .rst(rst), .in_vld(b_vld), .in_data(b_data),
        .out_vld(b_ovld), .out_win(b_win), .frame_done(b_fd)
    );

    typedef struct {
        int             cyc;
        logic [WWB-1:0] win;
        logic           last;
    } exp_t;

    exp_t           q0[$];
    exp_t           q1[$];
    logic [DW-1:0]  img [0:1][0:15][0:31];
    int             mr[2], mc[2], wd[2], ht[2];
    logic [WWB-1:0] held[2];
    int             vld_cnt[2], fd_cnt[2];
    logic [WWB-1:0] got[$];
    int             edge_n = 0;
    int             n_assert = 0;
    int             n_fail = 0;

    // Reference: remember every pixel at its (row, col); an interior pixel yields its 3x3 block two edges later.
    task automatic model(input int d, input logic v, input logic [DW-1:0] x, input logic r);
        exp_t e;
        if (r) begin
            if (d == 0) q0.delete(); else q1.delete();
            mr[d]   = 0;
            mc[d]   = 0;
            held[d] = '0;
        end else if (v) begin
            img[d][mr[d]][mc[d]] = x;
            if (mr[d] >= 2 && mc[d] >= 2) begin
                e.cyc  = edge_n + 1;
                e.last = (mr[d] == ht[d] - 1) && (mc[d] == wd[d] - 1);
                for (int k = 0; k < 9; k++)
                    e.win[k*DW +: DW] = img[d][mr[d] - 2 + k / 3][mc[d] - 2 + k % 3];
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            mc[d]++;
            if (mc[d] == wd[d]) begin
                mc[d] = 0;
                mr[d]++;
                if (mr[d] == ht[d]) mr[d] = 0;
            end
        end
    endtask

    task automatic check(input int d, input logic ov, input logic [WWB-1:0] ow, input logic of);
        exp_t e;
        logic have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0 && q0[0].cyc == edge_n) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() > 0 && q1[0].cyc == edge_n) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        if (ov === 1'b1) vld_cnt[d]++;
        if (ov === 1'b1 && of === 1'b1) fd_cnt[d]++;
        if (d == 0 && ov === 1'b1) got.push_back(ow);
        n_assert++;
        assert (ov === have) else begin
            n_fail++;
            $error("FAIL out_vld dut%0d edge %0d: observed %b expected %b", d, edge_n, ov, have);
        end
        if (have) begin
            n_assert++;
            assert (ow === e.win) else begin
                n_fail++;
                $error("FAIL out_win dut%0d edge %0d: observed %h expected %h", d, edge_n, ow, e.win);
            end
            n_assert++;
            assert (of === e.last) else begin
                n_fail++;
                $error("FAIL frame_done dut%0d edge %0d: observed %b expected %b", d, edge_n, of, e.last);
            end
            held[d] = e.win;
        end else begin
            n_assert++;
            assert (ow === held[d]) else begin
                n_fail++;
                $error("FAIL out_win_hold dut%0d edge %0d: observed %h expected %h", d, edge_n, ow, held[d]);
            end
            n_assert++;
            assert (of === 1'b0) else begin
                n_fail++;
                $error("FAIL frame_done_idle dut%0d edge %0d: observed %b expected 0", d, edge_n, of);
            end
        end
    endtask

    task automatic tick(input logic v0, input logic [DW-1:0] x0,
                        input logic v1, input logic [DW-1:0] x1, input logic r);
        s_vld  = v0;
        s_data = x0;
        b_vld  = v1;
        b_data = x1;
        rst    = r;
        @(posedge clk);
        edge_n++;
        model(0, v0, x0, r);
        model(1, v1, x1, r);
        #1;
        check(0, s_ovld, s_win, s_fd);
        check(1, b_ovld, b_win, b_fd);
    endtask

    task automatic px(input logic v, input logic [DW-1:0] x);
        tick(v, x, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 8'h00);
    endtask

    // Sends the first npix pixels of a 4x4 frame (16*row+col+base); gapped mode inserts 2,1,2,1... idle cycles.
    task automatic frame(input logic [DW-1:0] base, input int npix, input bit gapped);
        for (int i = 0; i < npix; i++) begin
            px(1'b1, base + DW'(16 * (i / SW) + (i % SW)));
            if (gapped) idle((i % 2 == 0) ? 2 : 1);
        end
    endtask

    task automatic clear_counts();
        vld_cnt = '{0, 0};
        fd_cnt  = '{0, 0};
        got.delete();
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_win(input string tag, input logic [WWB-1:0] obs, input logic [WWB-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int accepted;
        logic v;
        wd = '{SW, BW};
        ht = '{SH, BH};
        held = '{'0, '0};
        clear_counts();

        // Reset while pixels are offered: every output must be 0 during and after.
        tick(1'b1, 8'h55, 1'b1, 8'hAA, 1'b1);
        tick(1'b1, 8'h56, 1'b1, 8'hAB, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(2);
        chk_win("reset_out_win", s_win, '0);
        chk_int("reset_out_vld_count", vld_cnt[0], 0);

        // One frame, in_vld held high.
        clear_counts();
        frame(8'h00, SW * SH, 1'b0);
        idle(4);
        chk_int("s1_windows", vld_cnt[0], 4);
        chk_int("s1_frame_done", fd_cnt[0], 1);
        chk_win("s1_first", got[0], S1_FIRST);
        chk_win("s1_last", got[3], S1_LAST);

        // Same frame with gaps in in_vld.
        clear_counts();
        frame(8'h00, SW * SH, 1'b1);
        idle(4);
        chk_int("s2_windows", vld_cnt[0], 4);
        chk_int("s2_frame_done", fd_cnt[0], 1);
        chk_win("s2_first", got[0], S1_FIRST);
        chk_win("s2_last", got[3], S1_LAST);

        // Two back-to-back frames, second offset by 0x80.
        clear_counts();
        frame(8'h00, SW * SH, 1'b0);
        frame(8'h80, SW * SH, 1'b0);
        idle(4);
        chk_int("s3_windows", vld_cnt[0], 8);
        chk_int("s3_frame_done", fd_cnt[0], 2);
        chk_win("s3_f2_first", got[4], F2_FIRST);
        chk_win("s3_f2_last", got[7], F2_LAST);

        // Reset after 7 pixels (with in_vld high on the reset cycle), then a full frame.
        clear_counts();
        frame(8'h00, 7, 1'b0);
        tick(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        frame(8'h00, SW * SH, 1'b0);
        idle(4);
        chk_int("s4_windows", vld_cnt[0], 4);
        chk_win("s4_first", got[0], S1_FIRST);
        chk_win("s4_last", got[3], S1_LAST);

        // Reset right after pixel (2,2): its in-flight window must be discarded.
        clear_counts();
        frame(8'h00, 11, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        idle(3);
        chk_int("s4b_discarded", vld_cnt[0], 0);
        frame(8'h00, SW * SH, 1'b0);
        idle(4);
        chk_int("s4b_windows", vld_cnt[0], 4);
        chk_win("s4b_first", got[0], S1_FIRST);

        // Random pixels with random gaps on the larger instance, two frames.
        clear_counts();
        accepted = 0;
        while (accepted < 2 * BW * BH) begin
            v = ($urandom_range(0, 3) != 0);
            tick(1'b0, 8'h00, v, DW'($urandom), 1'b0);
            if (v) accepted++;
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk_int("s5_windows", vld_cnt[1], 2 * (BW - 2) * (BH - 2));
        chk_int("s5_frame_done", fd_cnt[1], 2);
        chk_int("pending_small", q0.size(), 0);
        chk_int("pending_big", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
